// File: rtl/n_clic.sv
// Nested-priority interrupt arbiter: a comparison tree picks the most urgent
// pending+enabled source each cycle; winner index/priority are registered.
module n_clic #(
    parameter type IntIndex    = logic [2:0],
    parameter type IntPriority = logic [1:0]
) (
    input  logic       clk,
    input  logic       reset,
    input  IntPriority i_priorities [2**$bits(IntIndex)],
    input  logic       i_pendings   [2**$bits(IntIndex)],
    input  logic       i_enables    [2**$bits(IntIndex)],
    input  logic       i_global_ie,
    output logic       o_int,
    output IntIndex    o_idx,
    output IntPriority o_prio
);
    localparam int IdxW = $bits(IntIndex);
    localparam int N    = 2**IdxW;

    // Heap-ordered tree: node k has children 2k and 2k+1, leaf i sits at N+i,
    // node 1 is the root. Invalid nodes always carry prio=0, idx=0.
    logic       node_valid [1:2*N-1];
    IntPriority node_prio  [1:2*N-1];
    IntIndex    node_idx   [1:2*N-1];

    logic       int_d, int_q;
    IntIndex    idx_d, idx_q;
    IntPriority prio_d, prio_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_leaf
        assign node_valid[N+gi] = i_pendings[gi] & i_enables[gi];
        assign node_prio[N+gi]  = node_valid[N+gi] ? i_priorities[gi] : '0;
        assign node_idx[N+gi]   = node_valid[N+gi] ? IntIndex'(gi) : '0;
    end

    for (genvar gi = 1; gi < N; gi++) begin : g_node
        logic take_right;
        // Right child only wins on strictly higher priority, so ties favour
        // the lower index on the left.
        assign take_right = node_valid[2*gi+1] &
                            (~node_valid[2*gi] | (node_prio[2*gi+1] > node_prio[2*gi]));
        assign node_valid[gi] = node_valid[2*gi] | node_valid[2*gi+1];
        assign node_prio[gi]  = take_right ? node_prio[2*gi+1] : node_prio[2*gi];
        assign node_idx[gi]   = take_right ? node_idx[2*gi+1]  : node_idx[2*gi];
    end

    always_comb begin
        int_d  = node_valid[1] & i_global_ie;
        idx_d  = node_idx[1];
        prio_d = node_prio[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_q  <= 1'b0;
            idx_q  <= '0;
            prio_q <= '0;
        end else begin
            int_q  <= int_d;
            idx_q  <= idx_d;
            prio_q <= prio_d;
        end
    end

    assign o_int  = int_q;
    assign o_idx  = idx_q;
    assign o_prio = prio_q;
endmodule

// File: tb/tb_n_clic.sv
// Self-checking bench for n_clic: directed cases plus randomized cycles
// compared against a linear-scan reference model.
module tb_n_clic;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] pr  [N];
    logic       pd  [N];
    logic       en  [N];
    logic       gie;
    logic       o_int;
    logic [2:0] o_idx;
    logic [1:0] o_prio;

    int checks = 0;
    int errors = 0;

    int exp_int, exp_idx, exp_prio;

    n_clic dut (
        .clk          (clk),
        .reset        (reset),
        .i_priorities (pr),
        .i_pendings   (pd),
        .i_enables    (en),
        .i_global_ie  (gie),
        .o_int        (o_int),
        .o_idx        (o_idx),
        .o_prio       (o_prio)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] p, input logic [7:0] pend,
                        input logic [7:0] ena, input logic g);
        for (int i = 0; i < N; i++) begin
            pr[i] = p[2*i +: 2];
            pd[i] = pend[i];
            en[i] = ena[i];
        end
        gie = g;
    endtask

    // Reference: scan all sources for the maximum priority, lowest index on ties.
    task automatic model();
        int best;
        best = -1;
        for (int i = 0; i < N; i++)
            if (pd[i] && en[i] && (best < 0 || int'(pr[i]) > int'(pr[best])))
                best = i;
        exp_int  = (best >= 0 && gie) ? 1 : 0;
        exp_idx  = (best >= 0) ? best : 0;
        exp_prio = (best >= 0) ? int'(pr[best]) : 0;
    endtask

    task automatic check_outs(input string tag, input int ei, input int ex, input int ep);
        check({tag, ".int"},  int'(o_int),  ei);
        check({tag, ".idx"},  int'(o_idx),  ex);
        check({tag, ".prio"}, int'(o_prio), ep);
    endtask

    // Apply current inputs, cross one edge, compare against explicit expectations.
    task automatic step_expect(input string tag, input int ei, input int ex, input int ep);
        @(posedge clk); #1;
        check_outs(tag, ei, ex, ep);
        $display("txn %s: int=%0d idx=%0d prio=%0d", tag, o_int, o_idx, o_prio);
    endtask

    initial begin
        reset = 1'b1;
        load(16'h0000, 8'h00, 8'h00, 1'b0);
        #2;
        check_outs("reset_init", 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        load(16'h0630, 8'b11010110, 8'b11111001, 1'b1);
        step_expect("plan_basic", 1, 4, 2);
        load(16'h0630, 8'b11010110, 8'b11111001, 1'b0);
        step_expect("plan_gie0", 0, 4, 2);
        load(16'h0CC0, 8'b00101000, 8'b00101000, 1'b1);
        step_expect("tie_3_5", 1, 3, 3);
        load(16'hFFFF, 8'hFF, 8'h00, 1'b1);
        step_expect("none", 0, 0, 0);
        load(16'h0000, 8'h80, 8'h80, 1'b1);
        step_expect("only7_p0", 1, 7, 0);
        load(16'hAAAA, 8'hFF, 8'hFF, 1'b1);
        step_expect("all_equal", 1, 0, 2);
        load(16'hC000, 8'hFF, 8'hFF, 1'b1);
        step_expect("top7_p3", 1, 7, 3);

        // Asynchronous reset between edges while o_int is high.
        load(16'h0630, 8'b11010110, 8'b11111001, 1'b1);
        step_expect("pre_reset", 1, 4, 2);
        #2 reset = 1'b1;
        #1 check_outs("reset_async", 0, 0, 0);
        @(posedge clk); #1;
        check_outs("reset_held", 0, 0, 0);
        reset = 1'b0;
        step_expect("reset_release", 1, 4, 2);

        for (int n = 0; n < 1000; n++) begin
            load(16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            model();
            @(posedge clk); #1;
            check_outs($sformatf("rand%0d", n), exp_int, exp_idx, exp_prio);
            $display("txn rand%0d: int=%0d idx=%0d prio=%0d", n, o_int, o_idx, o_prio);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
